// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM state type, default width.
package muldiv_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned OP_W      = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_MULT  = 3'b000;
  localparam op_t OP_MULTU = 3'b001;
  localparam op_t OP_DIV   = 3'b010;
  localparam op_t OP_DIVU  = 3'b011;
  localparam op_t OP_MTHI  = 3'b100;
  localparam op_t OP_MTLO  = 3'b101;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_hilo_div_core.sv
// Restoring-division datapath on unsigned magnitudes; one quotient bit per step, stepped by the parent FSM.
module div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH+1:0] shifted_c;
  logic             ge_c;
  logic [WIDTH-1:0] rem_next_c;

  // Partial remainder shifted left with the next dividend bit, then one trial subtract.
  always_comb begin
    shifted_c  = {1'b0, rem_o, quo_o[WIDTH-1]};
    ge_c       = (shifted_c >= {2'b00, dsr_q});
    rem_next_c = ge_c ? WIDTH'(shifted_c - {2'b00, dsr_q}) : WIDTH'(shifted_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dsr_q <= '0;
      quo_o <= '0;
      rem_o <= '0;
    end else if (load_i) begin
      dsr_q <= divisor_i;
      quo_o <= dividend_i;
      rem_o <= '0;
    end else if (step_i) begin
      rem_o <= rem_next_c;
      quo_o <= {quo_o[WIDTH-2:0], ge_c};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit with HI/LO registers.
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU in a single cycle.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic             mul_q, neg_q, rneg_q, dz_q;
  logic [WIDTH-1:0] a_q, mcand_q;
  logic [PW-1:0]    prod_q;
  logic [WIDTH-1:0] div_quo, div_rem;

  logic             is_mul_c, is_div_c, a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic             load_c, step_c, fix_c, wr_hi_c, wr_lo_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [PW-1:0]    prod_fix_c;
  logic [WIDTH-1:0] res_hi_c, res_lo_c;
`ifdef MULDIV_FAST_MUL_EN
  logic             fast_c;
  logic [PW-1:0]    fast_prod_c;
`endif

  // Operand decode: signed ops have op_i[0] clear; work on magnitudes and fix signs at the end.
  always_comb begin
    is_mul_c = (op_i == OP_MULT) || (op_i == OP_MULTU);
    is_div_c = (op_i == OP_DIV)  || (op_i == OP_DIVU);
    a_neg_c  = ~op_i[0] & a_i[WIDTH-1];
    b_neg_c  = ~op_i[0] & b_i[WIDTH-1];
    a_mag_c  = a_neg_c ? WIDTH'(0) - a_i : a_i;
    b_mag_c  = b_neg_c ? WIDTH'(0) - b_i : b_i;
  end

`ifdef MULDIV_FAST_MUL_EN
  always_comb begin
    if (op_i[0])
      fast_prod_c = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
    else
      fast_prod_c = PW'($signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i}));
  end
`endif

  // Next-state and control decode; cancel outranks start.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    fix_c   = 1'b0;
    wr_hi_c = 1'b0;
    wr_lo_c = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
    fast_c  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i && !cancel_i) begin
          if (op_i == OP_MTHI) begin
            wr_hi_c = 1'b1;
          end else if (op_i == OP_MTLO) begin
            wr_lo_c = 1'b1;
          end else if (is_mul_c) begin
`ifdef MULDIV_FAST_MUL_EN
            fast_c  = 1'b1;
`else
            load_c  = 1'b1;
            state_d = ST_BUSY;
`endif
          end else if (is_div_c) begin
            load_c  = 1'b1;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (cancel_i) begin
          state_d = ST_IDLE;
        end else begin
          step_c = 1'b1;
          if (count_q == CW'(WIDTH - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        fix_c   = !cancel_i;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shift-add step and final sign/special-case fix-up.
  always_comb begin
    mul_sum_c  = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
    prod_fix_c = neg_q ? PW'(0) - prod_q : prod_q;
    if (mul_q) begin
      res_hi_c = prod_fix_c[PW-1:WIDTH];
      res_lo_c = prod_fix_c[WIDTH-1:0];
    end else if (dz_q) begin
      res_hi_c = a_q;
      res_lo_c = '1;
    end else begin
      res_hi_c = rneg_q ? WIDTH'(0) - div_rem : div_rem;
      res_lo_c = neg_q  ? WIDTH'(0) - div_quo : div_quo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      busy_o <= (state_d != ST_IDLE);
      if (load_c) begin
        count_q <= '0;
        mul_q   <= is_mul_c;
        neg_q   <= a_neg_c ^ b_neg_c;
        rneg_q  <= a_neg_c;
        dz_q    <= is_div_c && (b_i == '0);
        a_q     <= a_i;
        mcand_q <= a_mag_c;
        prod_q  <= {WIDTH'(0), b_mag_c};
      end else if (step_c) begin
        count_q <= count_q + CW'(1);
        prod_q  <= {mul_sum_c, prod_q[WIDTH-1:1]};
      end
      if (wr_hi_c) hi_o <= a_i;
      if (wr_lo_c) lo_o <= a_i;
      if (fix_c) begin
        hi_o   <= res_hi_c;
        lo_o   <= res_lo_c;
        done_o <= 1'b1;
      end
`ifdef MULDIV_FAST_MUL_EN
      if (fast_c) begin
        hi_o   <= fast_prod_c[PW-1:WIDTH];
        lo_o   <= fast_prod_c[WIDTH-1:0];
        done_o <= 1'b1;
      end
`endif
    end
  end

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_c),
    .step_i     (step_c),
    .dividend_i (a_mag_c),
    .divisor_i  (b_mag_c),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed self-checking bench for muldiv_hilo: results, latency, MTHI/MTLO, cancel, reset and ignored starts.
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  logic         clk = 1'b0;
  logic         rst, start_i, cancel_i;
  logic [2:0]   op_i;
  logic [W-1:0] a_i, b_i, hi_o, lo_o;
  logic         busy_o, done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_hilo #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .cancel_i (cancel_i),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op_i    = op;
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    op_i    = 3'b110;
  endtask

  // Waits (bounded) for done_o, counting busy cycles; a timeout shows up as a failed done check.
  task automatic wait_done(input string tag, input int exp_busy);
    int nbusy = 0;
    int n = 0;
    while (done_o !== 1'b1 && n < 100) begin
      if (busy_o === 1'b1) nbusy++;
      @(negedge clk);
      n++;
    end
    check({tag, " done"}, W'(done_o), W'(1));
    check({tag, " busy_cycles"}, W'(nbusy), W'(exp_busy));
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input int exp_busy);
    issue(op, a, b);
    wait_done(tag, exp_busy);
    check({tag, " hi"}, hi_o, exp_hi);
    check({tag, " lo"}, lo_o, exp_lo);
    @(negedge clk);
    check({tag, " done_pulse"}, W'(done_o), W'(0));
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0;
    op_i = 3'b110; a_i = '0; b_i = '0;
    repeat (2) @(negedge clk);
    check("reset hi", hi_o, 32'h0);
    check("reset lo", lo_o, 32'h0);
    check("reset busy", W'(busy_o), W'(0));
    check("reset done", W'(done_o), W'(0));
    rst = 1'b0;

    run_op("mult",  OP_MULT,  32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, MUL_BUSY);
    run_op("multu", OP_MULTU, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, MUL_BUSY);
    run_op("mult_pos_neg", OP_MULT, 32'h00010000, 32'hFFFF0000, 32'hFFFFFFFF, 32'h00000000, MUL_BUSY);
    run_op("div_neg",  OP_DIV,  32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_BUSY);
    run_op("div_nd",   OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_BUSY);
    run_op("divu",     OP_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, DIV_BUSY);
    run_op("divu_dz",  OP_DIVU, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, DIV_BUSY);
    run_op("div_dz",   OP_DIV,  32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, DIV_BUSY);
    run_op("div_ovf",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_BUSY);

    issue(OP_MTHI, 32'h12345678, 32'h0);
    check("mthi hi", hi_o, 32'h12345678);
    check("mthi lo", lo_o, 32'h80000000);
    check("mthi busy", W'(busy_o), W'(0));
    check("mthi done", W'(done_o), W'(0));
    issue(OP_MTLO, 32'h9ABCDEF0, 32'h0);
    check("mtlo lo", lo_o, 32'h9ABCDEF0);
    check("mtlo hi", hi_o, 32'h12345678);
    check("mtlo busy", W'(busy_o), W'(0));

    // Cancel at busy cycle 10.
    issue(OP_DIVU, 32'd100, 32'd3);
    check("cancel busy_at_start", W'(busy_o), W'(1));
    repeat (9) @(negedge clk);
    cancel_i = 1'b1;
    @(negedge clk);
    cancel_i = 1'b0;
    check("cancel busy_drop", W'(busy_o), W'(0));
    seen_done = done_o;
    repeat (40) begin
      @(negedge clk);
      if (done_o === 1'b1) seen_done = 1'b1;
    end
    check("cancel no_done", W'(seen_done), W'(0));
    check("cancel hi", hi_o, 32'h12345678);
    check("cancel lo", lo_o, 32'h9ABCDEF0);

    // MTHI issued while busy must be ignored.
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    op_i = OP_MTHI; a_i = 32'hDEADBEEF; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; op_i = 3'b110;
    check("busy_start hi_kept", hi_o, 32'h12345678);
    wait_done("busy_start", DIV_BUSY - 5);
    check("busy_start hi", hi_o, 32'h00000002);
    check("busy_start lo", lo_o, 32'h0000000E);

    // Cancel together with start in IDLE drops the start.
    @(negedge clk);
    op_i = OP_MTHI; a_i = 32'h00000055; start_i = 1'b1; cancel_i = 1'b1;
    @(negedge clk);
    check("idle_cancel mthi hi", hi_o, 32'h00000002);
    op_i = OP_DIVU; a_i = 32'd9; b_i = 32'd2;
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b0; op_i = 3'b110;
    check("idle_cancel div busy", W'(busy_o), W'(0));
    @(negedge clk);
    check("idle_cancel div done", W'(done_o), W'(0));

    issue(3'b110, 32'd77, 32'd1);
    check("nop hi", hi_o, 32'h00000002);
    check("nop lo", lo_o, 32'h0000000E);
    check("nop busy", W'(busy_o), W'(0));

    // Reset mid-divide discards everything.
    issue(OP_DIVU, 32'd50, 32'd5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset hi", hi_o, 32'h0);
    check("midreset lo", lo_o, 32'h0);
    check("midreset busy", W'(busy_o), W'(0));
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o === 1'b1) seen_done = 1'b1;
    end
    check("midreset no_done", W'(seen_done), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
